// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Purpose : Opcode encodings and the FSM state type shared by the
//           multi-cycle ALU, its multiply/divide core and its testbench.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_LUI   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_SLL   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_muldiv_core.sv
// ---------------------------------------------------------------------------
// alu_muldiv_core
// Purpose : Iterative unsigned multiply (shift-add) and restoring divide,
//           one bit per clock, WIDTH iterations per operation.
// Ports   : i_clk      - rising-edge clock
//           i_reset    - synchronous active-low reset, aborts any operation
//           i_start    - load operands and begin an operation
//           i_isDiv    - 1 selects divide, 0 selects multiply (at i_start)
//           i_a, i_b   - multiplier/multiplicand or dividend/divisor
//           o_finish   - high during the final iteration cycle
//           o_nextHi   - HI after the current iteration (product high /
//                        remainder)
//           o_nextLo   - LO after the current iteration (product low /
//                        quotient)
// ---------------------------------------------------------------------------
module alu_muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_isDiv,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_finish,
  output logic [WIDTH-1:0] o_nextHi,
  output logic [WIDTH-1:0] o_nextLo
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_count;
  logic             r_isDiv;

  logic [WIDTH:0]   w_mulSum;
  logic [WIDTH:0]   w_divShift;
  logic [WIDTH:0]   w_divTrial;
  logic             w_divFits;

  // One iteration of either algorithm. The top registers these values on
  // the finishing cycle, so the last iteration's result is never lost.
  // Multiply: {hi,lo} holds {partial product, remaining multiplier bits};
  // add the multiplicand when the current multiplier bit is set, then
  // shift the whole pair right by one.
  // Divide: shift the next dividend bit into the remainder and subtract
  // the divisor only if it fits; the fit bit becomes the next quotient bit.
  always_comb begin
    w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_divShift = {r_hi, r_lo[WIDTH-1]};
    w_divTrial = w_divShift - {1'b0, r_b};
    w_divFits  = (w_divShift >= {1'b0, r_b});
    o_nextHi   = w_mulSum[WIDTH:1];
    o_nextLo   = {w_mulSum[0], r_lo[WIDTH-1:1]};
    if (r_isDiv) begin
      o_nextHi = w_divFits ? w_divTrial[WIDTH-1:0] : w_divShift[WIDTH-1:0];
      o_nextLo = {r_lo[WIDTH-2:0], w_divFits};
    end
  end

  assign o_finish = (r_count == CW'(1));

  // Operand load on start, then one iteration per clock while the counter
  // is nonzero. A counter of zero means the core is idle.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_isDiv <= 1'b0;
      r_count <= '0;
    end else if (i_start) begin
      r_hi    <= '0;
      r_lo    <= i_a;
      r_b     <= i_b;
      r_isDiv <= i_isDiv;
      r_count <= CW'(WIDTH);
    end else if (r_count != '0) begin
      r_hi    <= o_nextHi;
      r_lo    <= o_nextLo;
      r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
// Purpose : EX-stage ALU with registered outputs, single-cycle logic and
//           shift ops, and iterative MULTU/DIVU producing HI/LO, behind a
//           valid/ready/done handshake.
// Ports   : clk             - rising-edge clock
//           reset           - synchronous active-low reset
//           valid_i         - operation request
//           alu_operation_i - opcode (see alu_pkg)
//           a_i             - operand A; low SHW bits are the shift amount
//           b_i             - operand B
//           ready_o         - request can be accepted (IDLE only)
//           done_o          - one-cycle pulse, results valid
//           alu_data_o      - primary result; LO for MULTU/DIVU
//           hi_data_o       - HI for MULTU/DIVU, 0 otherwise
//           zero_o          - alu_data_o == 0, updated at completion
//           div_zero_o      - DIVU by zero, updated at completion
// ---------------------------------------------------------------------------
module alu_multicycle
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [3:0]       alu_operation_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] alu_data_o,
  output logic [WIDTH-1:0] hi_data_o,
  output logic             zero_o,
  output logic             div_zero_o
);

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_aluData;
  logic [WIDTH-1:0] r_hiData;
  logic             r_zero;
  logic             r_divZero;

  logic             w_accept;
  logic             w_start;
  logic             w_isDiv;
  logic             w_finish;
  logic [WIDTH-1:0] w_nextHi;
  logic [WIDTH-1:0] w_nextLo;
  logic [WIDTH-1:0] w_simpleResult;
  logic [SHW-1:0]   w_shamt;

  assign w_accept = valid_i && (r_state == IDLE);
  assign w_isDiv  = (alu_operation_i == OP_DIVU);
  assign w_shamt  = a_i[SHW-1:0];

  alu_muldiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_start  (w_start),
    .i_isDiv  (w_isDiv),
    .i_a      (a_i),
    .i_b      (b_i),
    .o_finish (w_finish),
    .o_nextHi (w_nextHi),
    .o_nextLo (w_nextLo)
  );

  // Results of every op that completes in one cycle. Invalid opcodes fall
  // through to zero, which also makes zero_o read 1 for them.
  always_comb begin
    w_simpleResult = '0;
    case (alu_operation_i)
      OP_LUI: w_simpleResult = {b_i[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_OR:  w_simpleResult = a_i | b_i;
      OP_AND: w_simpleResult = a_i & b_i;
      OP_ADD: w_simpleResult = a_i + b_i;
      OP_SUB: w_simpleResult = a_i - b_i;
      OP_NOR: w_simpleResult = ~(a_i | b_i);
      OP_SLT: w_simpleResult = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLL: w_simpleResult = b_i << w_shamt;
      OP_SRL: w_simpleResult = b_i >> w_shamt;
      default: w_simpleResult = '0;
    endcase
  end

  // Next-state logic. Division by zero needs no iteration, so it goes
  // straight to DONE like a single-cycle op and never starts the core.
  always_comb begin
    w_stateNext = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (alu_operation_i == OP_MULTU) begin
            w_stateNext = MUL;
            w_start     = 1'b1;
          end else if (w_isDiv && (b_i != '0)) begin
            w_stateNext = DIV;
            w_start     = 1'b1;
          end else begin
            w_stateNext = DONE;
          end
        end
      end
      MUL, DIV: begin
        if (w_finish) begin
          w_stateNext = DONE;
        end
      end
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // State register; reset also aborts the core through its own reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Output registers change only on the edge that enters DONE, so results
  // hold steady between completions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_aluData <= '0;
      r_hiData  <= '0;
      r_zero    <= 1'b0;
      r_divZero <= 1'b0;
    end else if (w_accept && !w_start && (alu_operation_i != OP_MULTU)) begin
      if (w_isDiv) begin
        r_aluData <= '1;
        r_hiData  <= a_i;
        r_zero    <= 1'b0;
        r_divZero <= 1'b1;
      end else begin
        r_aluData <= w_simpleResult;
        r_hiData  <= '0;
        r_zero    <= (w_simpleResult == '0);
        r_divZero <= 1'b0;
      end
    end else if (((r_state == MUL) || (r_state == DIV)) && w_finish) begin
      r_aluData <= w_nextLo;
      r_hiData  <= w_nextHi;
      r_zero    <= (w_nextLo == '0);
      r_divZero <= 1'b0;
    end
  end

  assign ready_o    = (r_state == IDLE);
  assign done_o     = (r_state == DONE);
  assign alu_data_o = r_aluData;
  assign hi_data_o  = r_hiData;
  assign zero_o     = r_zero;
  assign div_zero_o = r_divZero;

endmodule

// File: tb/tb_alu_multicycle.sv
// ---------------------------------------------------------------------------
// tb_alu_multicycle
// Purpose : Directed self-checking bench for alu_multicycle (WIDTH=32).
// Ports   : none (top-level bench)
// ---------------------------------------------------------------------------
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_i;
  logic [3:0]       alu_operation_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             ready_o;
  logic             done_o;
  logic [WIDTH-1:0] alu_data_o;
  logic [WIDTH-1:0] hi_data_o;
  logic             zero_o;
  logic             div_zero_o;

  int checks = 0;
  int errors = 0;
  int readyLeak = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  alu_multicycle #(
    .WIDTH (WIDTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .valid_i         (valid_i),
    .alu_operation_i (alu_operation_i),
    .a_i             (a_i),
    .b_i             (b_i),
    .ready_o         (ready_o),
    .done_o          (done_o),
    .alu_data_o      (alu_data_o),
    .hi_data_o       (hi_data_o),
    .zero_o          (zero_o),
    .div_zero_o      (div_zero_o)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Counts one comparison and reports it when the observed value differs.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge, where outputs are settled.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Waits for ready, presents one request for one edge, scrambles the
  // inputs to prove they were captured, then waits for done_o. latency is
  // the number of edges from acceptance to the edge that samples done_o=1.
  // pokeCycle != 0 raises valid_i for two cycles mid-operation.
  task automatic applyStimulus(input string tag, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input int pokeCycle, output int latency);
    int waited;
    waited  = 0;
    latency = 0;
    while (!ready_o && waited < 100) begin
      stepCycle();
      waited++;
    end
    if (!ready_o) begin
      checkOutput({tag, "_readyTimeout"}, 64'd0, 64'd1);
      return;
    end
    alu_operation_i = op;
    a_i             = a;
    b_i             = b;
    valid_i         = 1'b1;
    stepCycle();
    valid_i         = 1'b0;
    a_i             = ~a;
    b_i             = ~b;
    alu_operation_i = OP_ADD;
    latency         = 1;
    while (!done_o && latency < 200) begin
      if (ready_o) readyLeak++;
      if (pokeCycle != 0 && latency == pokeCycle) valid_i = 1'b1;
      if (pokeCycle != 0 && latency == pokeCycle + 2) valid_i = 1'b0;
      stepCycle();
      latency++;
    end
    valid_i = 1'b0;
    if (!done_o) checkOutput({tag, "_doneTimeout"}, 64'd0, 64'd1);
  endtask

  // done_o must be a single-cycle pulse followed by a return to IDLE.
  task automatic checkPulseEnd(input string tag);
    stepCycle();
    checkOutput({tag, "_doneFall"}, 64'(done_o), 64'd0);
    checkOutput({tag, "_readyBack"}, 64'(ready_o), 64'd1);
  endtask

  // Directed sequence: reset, MULTU with mid-op request, single-cycle
  // table, DIVU, reset abort, back-to-back requests.
  initial begin
    int lat;
    int extra;

    vecs[0]  = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[1]  = '{OP_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE};
    vecs[2]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    vecs[3]  = '{OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000};
    vecs[4]  = '{OP_LUI,  32'h00000000, 32'h1234ABCD, 32'hABCD0000};
    vecs[5]  = '{OP_SLL,  32'h00000004, 32'h00000001, 32'h00000010};
    vecs[6]  = '{OP_SLL,  32'h00000023, 32'h00000001, 32'h00000008};
    vecs[7]  = '{OP_SRL,  32'h00000004, 32'h80000000, 32'h08000000};
    vecs[8]  = '{OP_OR,   32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F};
    vecs[9]  = '{OP_AND,  32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00};
    vecs[10] = '{OP_NOR,  32'hFFFF0000, 32'h0000FFFF, 32'h00000000};
    vecs[11] = '{4'b1111, 32'h00001234, 32'h00005678, 32'h00000000};

    reset           = 1'b0;
    valid_i         = 1'b0;
    alu_operation_i = '0;
    a_i             = '0;
    b_i             = '0;
    repeat (3) stepCycle();
    checkOutput("rst_ready",   64'(ready_o),    64'd1);
    checkOutput("rst_done",    64'(done_o),     64'd0);
    checkOutput("rst_alu",     64'(alu_data_o), 64'd0);
    checkOutput("rst_hi",      64'(hi_data_o),  64'd0);
    checkOutput("rst_zero",    64'(zero_o),     64'd0);
    checkOutput("rst_divZero", 64'(div_zero_o), 64'd0);
    reset = 1'b1;
    stepCycle();

    readyLeak = 0;
    applyStimulus("multu", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 10, lat);
    checkOutput("multu_latency",   64'(lat),        64'd33);
    checkOutput("multu_readyLeak", 64'(readyLeak),  64'd0);
    checkOutput("multu_lo",        64'(alu_data_o), 64'h00000001);
    checkOutput("multu_hi",        64'(hi_data_o),  64'hFFFFFFFE);
    checkOutput("multu_zero",      64'(zero_o),     64'd0);
    checkPulseEnd("multu");
    extra = 0;
    repeat (5) begin
      stepCycle();
      if (done_o) extra++;
    end
    checkOutput("multu_extraDone", 64'(extra), 64'd0);

    for (int i = 0; i < NV; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 0, lat);
      checkOutput($sformatf("vec%0d_latency", i), 64'(lat),        64'd1);
      checkOutput($sformatf("vec%0d_alu", i),     64'(alu_data_o), 64'(vecs[i].res));
      checkOutput($sformatf("vec%0d_hi", i),      64'(hi_data_o),  64'd0);
      checkOutput($sformatf("vec%0d_zero", i),    64'(zero_o),     64'(vecs[i].res == 32'd0));
      checkOutput($sformatf("vec%0d_divZero", i), 64'(div_zero_o), 64'd0);
      checkPulseEnd($sformatf("vec%0d", i));
    end

    applyStimulus("divu", OP_DIVU, 32'd100, 32'd7, 0, lat);
    checkOutput("divu_latency", 64'(lat),        64'd33);
    checkOutput("divu_lo",      64'(alu_data_o), 64'd14);
    checkOutput("divu_hi",      64'(hi_data_o),  64'd2);
    checkOutput("divu_divZero", 64'(div_zero_o), 64'd0);
    checkPulseEnd("divu");

    applyStimulus("divz", OP_DIVU, 32'd9, 32'd0, 0, lat);
    checkOutput("divz_latency", 64'(lat),        64'd1);
    checkOutput("divz_lo",      64'(alu_data_o), 64'hFFFFFFFF);
    checkOutput("divz_hi",      64'(hi_data_o),  64'd9);
    checkOutput("divz_divZero", 64'(div_zero_o), 64'd1);
    checkOutput("divz_zero",    64'(zero_o),     64'd0);
    checkPulseEnd("divz");

    alu_operation_i = OP_MULTU;
    a_i             = 32'd3;
    b_i             = 32'd5;
    valid_i         = 1'b1;
    stepCycle();
    valid_i = 1'b0;
    repeat (9) stepCycle();
    reset = 1'b0;
    stepCycle();
    reset = 1'b1;
    checkOutput("abort_ready",   64'(ready_o),    64'd1);
    checkOutput("abort_done",    64'(done_o),     64'd0);
    checkOutput("abort_alu",     64'(alu_data_o), 64'd0);
    checkOutput("abort_hi",      64'(hi_data_o),  64'd0);
    checkOutput("abort_zero",    64'(zero_o),     64'd0);
    checkOutput("abort_divZero", 64'(div_zero_o), 64'd0);
    extra = 0;
    repeat (40) begin
      stepCycle();
      if (done_o) extra++;
    end
    checkOutput("abort_noDone", 64'(extra), 64'd0);

    applyStimulus("add23", OP_ADD, 32'd2, 32'd3, 0, lat);
    checkOutput("add23_latency", 64'(lat),        64'd1);
    checkOutput("add23_alu",     64'(alu_data_o), 64'd5);
    checkPulseEnd("add23");

    alu_operation_i = OP_ADD;
    a_i             = 32'd1;
    b_i             = 32'd1;
    valid_i         = 1'b1;
    for (int k = 0; k < 8; k++) begin
      stepCycle();
      checkOutput($sformatf("b2b_done%0d", k), 64'(done_o), ((k % 2) == 0) ? 64'd1 : 64'd0);
    end
    valid_i = 1'b0;
    checkOutput("b2b_alu", 64'(alu_data_o), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised WIDTH-bit ALU for the MIPS datapath, successor to the single-cycle combinational ALU.
- Adds iterative unsigned multiply and divide with HI/LO results, SUB/AND/NOR/SLT/shift ops, and registered outputs.
- Uses a valid/ready/done handshake so the control unit can stall the pipeline.
- Sits in the EX stage. HI/LO results feed the mfhi/mflo path.

Parameters:
- WIDTH, 32, operand/result width; must be even and at least 4.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-low reset.
- valid_i, input, 1, operation request.
- alu_operation_i, input, 4, opcode (encodings below).
- a_i, input, WIDTH, operand A; a_i[SHW-1:0] is the shift amount for SLL/SRL.
- b_i, input, WIDTH, operand B.
- ready_o, output, 1, block can accept a request.
- done_o, output, 1, one-cycle pulse: results valid.
- alu_data_o, output, WIDTH, primary result; LO for MULTU/DIVU.
- hi_data_o, output, WIDTH, HI result for MULTU/DIVU; 0 for other ops.
- zero_o, output, 1, alu_data_o == 0, qualified by done_o.
- div_zero_o, output, 1, DIVU with b_i == 0, qualified by done_o.

Behaviour:
- Opcodes (shared package):
  - LUI=0000, OR=0001, AND=0010, ADD=0011, SUB=0100, NOR=0101, SLT=0110 (signed)
  - SLL=0111 (b<<shamt), SRL=1000 (b>>shamt, logical), MULTU=1001, DIVU=1010
  - Others are invalid.
- LUI: {b_i[WIDTH/2-1:0], WIDTH/2 zeros}.
- ADD/SUB: wrap modulo 2^WIDTH; no overflow trap.
- SLT: 1 if $signed(a) < $signed(b), else 0.
- Invalid opcode: alu_data_o=0, hi=0, zero_o=1, 1-cycle latency.
- Reset (reset==0 at clk edge):
  - state=IDLE, ready_o=1, done_o=0.
  - alu_data_o, hi_data_o = 0; zero_o=0; div_zero_o=0.
  - Reset mid-MUL/DIV aborts the operation; no done_o is produced.
- Handshake:
  - A request is accepted on the clock edge where valid_i && ready_o.
  - Operands and opcode are captured into internal registers at acceptance; the inputs may change afterwards.
  - ready_o is 1 only in IDLE. valid_i while ready_o=0 is ignored (not queued).
- FSM states IDLE, MUL, DIV, DONE:
  - IDLE -> DONE: single-cycle ops and invalid opcodes. The result is registered at acceptance; done_o=1 on the next cycle.
  - IDLE -> MUL (MULTU), IDLE -> DIV (DIVU): load operands, counter=WIDTH.
  - MUL: shift-add, one multiplier bit per cycle, counter decrements. At counter==1 -> DONE with {hi,lo} = a*b (2*WIDTH product).
  - DIV: restoring division, one quotient bit per cycle. Ends -> DONE with lo=quotient, hi=remainder.
  - DIVU with b==0 skips iteration: IDLE -> DONE; lo=all ones, hi=a, div_zero_o=1.
  - DONE: done_o=1 for exactly this cycle, ready_o=0 -> IDLE.
- Latency, acceptance edge to done_o high:
  - 1 cycle for single-cycle ops.
  - WIDTH+1 cycles for MULTU and for DIVU with nonzero divisor.
  - Throughput is one request per latency+1 cycles.
- Outputs hold their last values after done_o falls until the next completion. zero_o/div_zero_o update only at completion.

Decomposition:
- Package alu_pkg: opcode localparams, FSM state encoding.
- Sub-module alu_muldiv_core: MUL/DIV iteration datapath and counter, with start/op/finish interface. The top holds the FSM, single-cycle ops, and output registers.

Test Plan:
- ADD a=0xFFFFFFFF, b=1 -> done_o one cycle after acceptance, alu_data_o=0, zero_o=1.
- SUB a=5, b=7 -> 0xFFFFFFFE. SLT a=0xFFFFFFFF, b=1 -> 1. LUI b=0x1234ABCD -> 0xABCD0000. SLL a=4, b=1 -> 0x10.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done_o exactly 33 cycles after acceptance; hi=0xFFFFFFFE, lo=0x00000001. ready_o=0 throughout; a second valid_i mid-op produces no extra done_o.
- DIVU a=100, b=7 -> lo=14, hi=2 after 33 cycles. DIVU a=9, b=0 -> 1 cycle, lo=0xFFFFFFFF, hi=9, div_zero_o=1.
- reset=0 at cycle 10 of a MULTU -> next cycle ready_o=1, all outputs 0, no done_o. A following ADD 2+3 -> 5.
- Back-to-back ADD requests with valid_i held high -> accepted every second cycle, done_o pulses alternate. Opcode 1111 -> alu_data_o=0, zero_o=1.
